i2c_codec_cfg_seq: RTL and testbench

- Upstream driver of the I2C write master. Walks a fixed table of 11 WM8731-style register writes and issues one 3-byte write per entry.
- For each entry it presents the address and two data bytes, pulses `start`, then waits for `done`.
- Reports overall progress, completion and timeout error to the top level. Sits between the board-level reset/config logic and the I2C master.

---
 rtl/i2c_codec_cfg_seq.sv | 176 +++++++++++++++++
 tb/tb_i2c_codec_cfg_seq.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_codec_cfg_seq.sv
`default_nettype none
// ============================================================================
// Module   : i2c_codec_cfg_seq
// Purpose  : Codec configuration sequencer. Steps through a fixed table of
//            eleven WM8731-style register writes. For each entry it loads
//            the two data bytes, pulses `start` to the I2C write master and
//            waits for `done`. A timeout on `done` stops the sequence with
//            an error.
// Ports    : clk, reset_n       - clock, asynchronous active-low reset
//            go                 - run (or rerun) the table from entry 0
//            busy, done         - status from the I2C write master
//            start              - one-cycle transaction request
//            addr, wr_rd        - constant slave address / write direction
//            data_st, data_nd   - {reg[6:0], val[8]}, val[7:0]
//            idx                - current table entry (0..10)
//            cfg_busy, cfg_done, cfg_err - sequence status (done/err held)
// Options  : CFG_AUTO_START_EN - when defined, the table runs once by itself
//            on the first clock after reset release.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_codec_cfg_seq #(
    parameter logic [6:0] DEV_ADDR       = 7'h1A,
    parameter int         GAP_CYCLES     = 16,    // 1..255
    parameter int         TIMEOUT_CYCLES = 4096   // 2..65535
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       go,
    input  logic       busy,
    input  logic       done,
    output logic       start,
    output logic [6:0] addr,
    output logic       wr_rd,
    output logic [7:0] data_st,
    output logic [7:0] data_nd,
    output logic [3:0] idx,
    output logic       cfg_busy,
    output logic       cfg_done,
    output logic       cfg_err
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_ISSUE     = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_GAP       = 3'd4,
        S_FINISH    = 3'd5,
        S_ERROR     = 3'd6
    } state_t;

    localparam logic [15:0] c_to_last  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  c_gap_last = 8'(GAP_CYCLES - 1);
    localparam logic [3:0]  c_last_idx = 4'd10;

    state_t      r_state;
    logic [15:0] r_to_cnt;
    logic [7:0]  r_gap_cnt;
    logic [15:0] w_entry;
    logic        w_go;

    // Each entry is packed as {reg[6:0], val[8:0]}; this is bit-for-bit the
    // concatenation {data_st, data_nd}, so loading needs no reshuffling.
    function automatic logic [15:0] table_entry(input logic [3:0] i);
        logic [15:0] e;
        case (i)
            4'd0:    e = {7'd15, 9'h000};
            4'd1:    e = {7'd0,  9'h017};
            4'd2:    e = {7'd1,  9'h017};
            4'd3:    e = {7'd2,  9'h079};
            4'd4:    e = {7'd3,  9'h079};
            4'd5:    e = {7'd4,  9'h012};
            4'd6:    e = {7'd5,  9'h000};
            4'd7:    e = {7'd6,  9'h000};
            4'd8:    e = {7'd7,  9'h042};
            4'd9:    e = {7'd8,  9'h000};
            4'd10:   e = {7'd9,  9'h001};
            default: e = 16'h0000;
        endcase
        return e;
    endfunction

    assign w_entry = table_entry(idx);
    assign addr    = DEV_ADDR;
    assign wr_rd   = 1'b0;

`ifdef CFG_AUTO_START_EN
    // Set by reset, cleared on the first clock: acts as a single `go` seen
    // by IDLE right after reset release.
    logic r_auto;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_auto <= 1'b1;
        end else begin
            r_auto <= 1'b0;
        end
    end
    assign w_go = go | r_auto;
`else
    assign w_go = go;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_to_cnt  <= 16'd0;
            r_gap_cnt <= 8'd0;
            start     <= 1'b0;
            data_st   <= 8'd0;
            data_nd   <= 8'd0;
            idx       <= 4'd0;
            cfg_busy  <= 1'b0;
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            start <= 1'b0;
            case (r_state)
                // Idle and both terminal states share the (re)start path;
                // idx stays frozen in ERROR until the next go.
                S_IDLE, S_FINISH, S_ERROR: begin
                    if (w_go) begin
                        r_state  <= S_LOAD;
                        idx      <= 4'd0;
                        cfg_busy <= 1'b1;
                        cfg_done <= 1'b0;
                        cfg_err  <= 1'b0;
                    end
                end
                // Data is registered one cycle ahead of start so it is
                // already stable when the master latches on start's edge.
                S_LOAD: begin
                    {data_st, data_nd} <= w_entry;
                    r_state            <= S_ISSUE;
                end
                S_ISSUE: begin
                    start    <= 1'b1;
                    r_to_cnt <= 16'd0;
                    r_state  <= S_WAIT_DONE;
                end
                // done is checked before the timeout so a coincident done wins.
                S_WAIT_DONE: begin
                    if (done) begin
                        r_gap_cnt <= 8'd0;
                        r_state   <= S_GAP;
                    end else if (r_to_cnt == c_to_last) begin
                        r_state  <= S_ERROR;
                        cfg_busy <= 1'b0;
                        cfg_err  <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + 16'd1;
                    end
                end
                // The last gap cycle repeats while the master reports busy.
                S_GAP: begin
                    if (r_gap_cnt != c_gap_last) begin
                        r_gap_cnt <= r_gap_cnt + 8'd1;
                    end else if (!busy) begin
                        if (idx == c_last_idx) begin
                            r_state  <= S_FINISH;
                            cfg_busy <= 1'b0;
                            cfg_done <= 1'b1;
                        end else begin
                            idx     <= idx + 4'd1;
                            r_state <= S_LOAD;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_codec_cfg_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_codec_cfg_seq
// Purpose  : Self-checking bench for i2c_codec_cfg_seq. A behavioural I2C
//            master model answers each start with done after a per-entry
//            latency and may hold busy afterwards. A table of scenarios
//            (random latencies, hang, busy stretch, go held high, done at
//            the timeout boundary) is applied in a loop and every start,
//            its data and timing, and the final status are compared with
//            values computed from the register table and the timing rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_codec_cfg_seq;

    localparam int G = 16;
    localparam int T = 4096;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       go = 1'b0;
    logic       busy = 1'b0;
    logic       done = 1'b0;
    logic       start;
    logic [6:0] addr;
    logic       wr_rd;
    logic [7:0] data_st;
    logic [7:0] data_nd;
    logic [3:0] idx;
    logic       cfg_busy;
    logic       cfg_done;
    logic       cfg_err;

    i2c_codec_cfg_seq #(
        .DEV_ADDR       (7'h1A),
        .GAP_CYCLES     (G),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .go       (go),
        .busy     (busy),
        .done     (done),
        .start    (start),
        .addr     (addr),
        .wr_rd    (wr_rd),
        .data_st  (data_st),
        .data_nd  (data_nd),
        .idx      (idx),
        .cfg_busy (cfg_busy),
        .cfg_done (cfg_done),
        .cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Register table as written in the codec datasheet terms.
    int ref_reg[11] = '{15, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    int ref_val[11] = '{'h000, 'h017, 'h017, 'h079, 'h079, 'h012,
                        'h000, 'h000, 'h042, 'h000, 'h001};

    function automatic int exp_st(input int k);
        return ref_reg[k] * 2 + ref_val[k] / 256;
    endfunction

    function automatic int exp_nd(input int k);
        return ref_val[k] % 256;
    endfunction

    // ---------------- I2C master model ----------------
    int delays[11];
    int extra[11];
    int hang = -1;
    int base = 0;

    int cyc = 0;
    int n = 0;
    int done_cnt = -1;
    int busy_cnt = 0;
    int wide_cnt = 0;
    int stable_bad = 0;
    int mk = 0;
    int me = 0;
    logic start_prev = 1'b0;
    int cap_st[256];
    int cap_nd[256];
    int cap_idx[256];
    int cap_busy[256];
    int scyc[256];
    int dcyc[256];
    int bcyc[256];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!reset_n) begin
            done       = 1'b0;
            busy       = 1'b0;
            done_cnt   = -1;
            busy_cnt   = 0;
            start_prev = 1'b0;
        end else begin
            done = 1'b0;
            if (done_cnt > 0) begin
                done_cnt = done_cnt - 1;
                if (done_cnt == 0) begin
                    done     = 1'b1;
                    done_cnt = -1;
                    dcyc[n-1] = cyc;
                    if (data_st !== 8'(cap_st[n-1]) || data_nd !== 8'(cap_nd[n-1]))
                        stable_bad = stable_bad + 1;
                    mk = n - 1 - base;
                    me = (mk >= 0 && mk < 11) ? extra[mk] : 0;
                    if (me > 0) begin
                        busy_cnt = me;
                    end else begin
                        busy = 1'b0;
                        bcyc[n-1] = cyc;
                    end
                end
            end else if (busy_cnt > 0) begin
                busy_cnt = busy_cnt - 1;
                if (busy_cnt == 0) begin
                    busy = 1'b0;
                    bcyc[n-1] = cyc;
                end
            end
            if (start && start_prev) wide_cnt = wide_cnt + 1;
            if (start && !start_prev && n < 256) begin
                cap_st[n]   = int'(data_st);
                cap_nd[n]   = int'(data_nd);
                cap_idx[n]  = int'(idx);
                cap_busy[n] = int'(cfg_busy);
                scyc[n]     = cyc;
                mk = n - base;
                if (mk != hang) begin
                    done_cnt = (mk < 11) ? delays[mk] : 100;
                    busy     = 1'b1;
                end
                n = n + 1;
            end
            start_prev = start;
        end
    end

    // ---------------- scenario table ----------------
    typedef struct {
        int hang;        // entry whose done never comes (-1: none)
        int busy_entry;  // entry with stretched busy
        int busy_extra;  // stretch length (-1: random on every entry)
        int long_entry;  // entry answered exactly at the timeout boundary
        int hold_go;     // keep go high during the run
        int dmin;
        int dmax;
        int exp_starts;
        int exp_done;
        int exp_err;
        int exp_idx;
    } vec_t;

    task automatic run_vec(input int id, input vec_t v);
        int g;
        int fin;
        int st;
        int e_t;
        int lst;
        string nm;
        for (int i = 0; i < 11; i++) begin
            delays[i] = int'($urandom_range(v.dmax, v.dmin));
            if (i == v.long_entry) delays[i] = T - 1;
            if (v.busy_extra < 0) extra[i] = int'($urandom_range(30, 0));
            else extra[i] = (i == v.busy_entry) ? v.busy_extra : 0;
        end
        hang = v.hang;
        @(negedge clk); #1;
        base = n;
        go   = 1'b1;
        g    = cyc;
        if (v.hold_go == 0) begin
            @(negedge clk); #1;
            go = 1'b0;
        end
        fin = -1;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk); #1;
            if (v.hold_go != 0 && n - base >= 11) go = 1'b0;
            if (cfg_done || cfg_err) begin
                fin = cyc;
                break;
            end
        end
        go = 1'b0;
        nm = $sformatf("v%0d", id);
        chk({nm, "_completes"}, fin >= 0, 1);
        st = n - base;
        chk({nm, "_start_count"}, st, v.exp_starts);
        for (int k = 0; k < st && k < 11; k++) begin
            chk($sformatf("%s_e%0d_data_st", nm, k), cap_st[base+k], exp_st(k));
            chk($sformatf("%s_e%0d_data_nd", nm, k), cap_nd[base+k], exp_nd(k));
            chk($sformatf("%s_e%0d_idx", nm, k), cap_idx[base+k], k);
            chk($sformatf("%s_e%0d_cfg_busy", nm, k), cap_busy[base+k], 1);
            if (k == 0) e_t = g + 3;
            else e_t = imax(dcyc[base+k-1] + G, bcyc[base+k-1]) + 3;
            chk($sformatf("%s_e%0d_start_time", nm, k), scyc[base+k], e_t);
        end
        if (fin >= 0 && st > 0) begin
            lst = base + st - 1;
            if (v.exp_err != 0) e_t = scyc[lst] + T;
            else e_t = imax(dcyc[lst] + G, bcyc[lst]) + 1;
            chk({nm, "_finish_time"}, fin, e_t);
        end
        chk({nm, "_cfg_done"}, cfg_done, v.exp_done);
        chk({nm, "_cfg_err"}, cfg_err, v.exp_err);
        chk({nm, "_cfg_busy_end"}, cfg_busy, 0);
        chk({nm, "_idx_end"}, idx, v.exp_idx);
        repeat (5) @(negedge clk);
        #1;
        chk({nm, "_cfg_done_held"}, cfg_done, v.exp_done);
        chk({nm, "_cfg_err_held"}, cfg_err, v.exp_err);
        chk({nm, "_no_extra_start"}, n - base, st);
        chk({nm, "_start_width"}, wide_cnt, 0);
        chk({nm, "_data_stable"}, stable_bad, 0);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_start"}, start, 0);
        chk({nm, "_data_st"}, data_st, 0);
        chk({nm, "_data_nd"}, data_nd, 0);
        chk({nm, "_idx"}, idx, 0);
        chk({nm, "_cfg_busy"}, cfg_busy, 0);
        chk({nm, "_cfg_done"}, cfg_done, 0);
        chk({nm, "_cfg_err"}, cfg_err, 0);
        chk({nm, "_addr"}, addr, 7'h1A);
        chk({nm, "_wr_rd"}, wr_rd, 0);
    endtask

    vec_t vecs[8];
    int   m;
    int   got;

    initial begin
        //            hang be  bx  long hold dmin dmax  st dn er idx
        vecs[0] = '{-1, -1,  0,   -1,  0, 100, 100, 11, 1, 0, 10};
        vecs[1] = '{ 0, -1,  0,   -1,  0,  10,  10,  1, 0, 1,  0};
        vecs[2] = '{-1, -1,  0,   -1,  0,   1,  60, 11, 1, 0, 10};
        vecs[3] = '{-1, -1,  0,   -1,  1,   1,  80, 11, 1, 0, 10};
        vecs[4] = '{-1,  3, G+40, -1,  0, 100, 100, 11, 1, 0, 10};
        vecs[5] = '{ 6, -1, -1,   -1,  0,   1, 200,  7, 0, 1,  6};
        vecs[6] = '{-1, -1, -1,    2,  0,   5,  20, 11, 1, 0, 10};
        vecs[7] = '{-1, -1, -1,   -1,  0,   1, 300, 11, 1, 0, 10};

        repeat (3) @(negedge clk);
        #1;
        chk_reset_vals("reset");
        reset_n = 1'b1;
        repeat (60) @(negedge clk);
        #1;
        chk("no_start_without_go", n, 0);
        chk("idle_cfg_busy", cfg_busy, 0);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Reset while entry 5 is waiting for done.
        for (int i = 0; i < 11; i++) begin
            delays[i] = (i == 5) ? 1000 : 30;
            extra[i]  = 0;
        end
        hang = -1;
        @(negedge clk); #1;
        base = n;
        go   = 1'b1;
        @(negedge clk); #1;
        go  = 1'b0;
        got = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk); #1;
            if (n - base >= 6) begin
                got = 1;
                break;
            end
        end
        chk("rst_mid_reached_e5", got, 1);
        repeat (10) @(negedge clk);
        #1;
        chk("rst_mid_idx_before", idx, 5);
        chk("rst_mid_busy_before", cfg_busy, 1);
        #1;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("rst_mid_async");
        @(negedge clk); #1;
        reset_n = 1'b1;
        m = n;
        repeat (200) @(negedge clk);
        #1;
        chk("rst_mid_no_start_after", n, m);
        chk("rst_mid_cfg_busy_after", cfg_busy, 0);

        run_vec(8, vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
